// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style main control FSM for a multicycle MIPS-subset
// datapath. Each instruction takes several cycles. Every control output is
// decoded from the current state alone.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   run             - level; allows fetching the next instruction
//   Op              - IR[31:26]; sampled only in DECODE and MEM_ADR
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
//                   - datapath control strobes and selects
//   state           - current state code
//   halted          - high while the FSM sits in HALT (unknown opcode)
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EXE   = 4'd7,
    S_R_WB    = 4'd8,
    S_BEQ     = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Next-state decode. The terminal states of every instruction share the
  // same exit: go to FETCH when run is high, otherwise go to IDLE. This lets
  // dropping run finish the current instruction instead of aborting it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = S_MEM_ADR;
        else if (Op == OP_RTYPE)        state_d = S_R_EXE;
        else if (Op == OP_BEQ)          state_d = S_BEQ;
        else if (Op == OP_J)            state_d = S_JUMP;
        else if (Op == OP_ADDI)         state_d = S_ADDI_EX;
        else                            state_d = S_HALT;
      end
      S_MEM_ADR: state_d = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_R_EXE:   state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_MEM_WR, S_R_WB, S_BEQ, S_JUMP, S_ADDI_WB:
                 state_d = run ? S_FETCH : S_IDLE;
      S_HALT:    state_d = S_HALT;
      // Unused codes 13 and 14 fall into HALT.
      default:   state_d = S_HALT;
    endcase
  end

  // Moore output decode. Every output starts at 0. Each state then raises
  // only the outputs it needs.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_HALT:    halted   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl. It walks LW, SW,
// BEQ, J, ADDI and R-type instructions, drops run partway through an
// instruction, applies an asynchronous reset in the middle of a cycle, and
// drives an unknown opcode into HALT. It compares the state code and every
// control output against hand-written constants.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, halted;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector bit order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],halted}
  localparam logic [16:0] C_IDLE   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_MADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_REXE   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_AEX    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_AWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_HALT   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  logic [16:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                 PCSource, halted};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st,
                           input logic [16:0] c);
    chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
    chk({tag, ".ctrl"},  {15'd0, ctrl},  {15'd0, c});
  endtask

  // Advance one clock; return at the falling edge so that the outputs are
  // sampled half a period away from the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    Op    = 6'b000000;
    @(negedge clk);
    expect_st("reset", 4'd0, C_IDLE);
    rst_n = 1'b1;
    step();
    expect_st("idle_norun0", 4'd0, C_IDLE);
    step();
    expect_st("idle_norun1", 4'd0, C_IDLE);

    // LW: 0,1,2,3,4,5,1. Op is changed in MEM_RD, where it must be ignored.
    run = 1'b1;
    Op  = 6'b100011;
    step(); expect_st("lw_fetch", 4'd1, C_FETCH);
    step(); expect_st("lw_decode", 4'd2, C_DECODE);
    step(); expect_st("lw_madr", 4'd3, C_MADR);
    step(); expect_st("lw_mrd", 4'd4, C_MRD);
    Op = 6'b000010;
    step(); expect_st("lw_mwb", 4'd5, C_MWB);
    Op = 6'b101011;
    step(); expect_st("lw_next_fetch", 4'd1, C_FETCH);

    // SW: 1,2,3,6,1
    step(); expect_st("sw_decode", 4'd2, C_DECODE);
    step(); expect_st("sw_madr", 4'd3, C_MADR);
    step(); expect_st("sw_mwr", 4'd6, C_MWR);
    chk("sw_memread_low", {31'd0, MemRead}, 32'd0);
    Op = 6'b000100;
    step(); expect_st("sw_next_fetch", 4'd1, C_FETCH);

    // BEQ then J
    step(); expect_st("beq_decode", 4'd2, C_DECODE);
    step(); expect_st("beq_exec", 4'd9, C_BEQ);
    Op = 6'b000010;
    step(); expect_st("j_fetch", 4'd1, C_FETCH);
    step(); expect_st("j_decode", 4'd2, C_DECODE);
    step(); expect_st("j_exec", 4'd10, C_JUMP);
    Op = 6'b001000;
    step(); expect_st("addi_fetch", 4'd1, C_FETCH);

    // ADDI
    step(); expect_st("addi_decode", 4'd2, C_DECODE);
    step(); expect_st("addi_ex", 4'd11, C_AEX);
    step(); expect_st("addi_wb", 4'd12, C_AWB);
    Op = 6'b000000;
    step(); expect_st("r_fetch", 4'd1, C_FETCH);

    // R-type, with run dropped in R_EXE: the instruction completes, then IDLE.
    step(); expect_st("r_decode", 4'd2, C_DECODE);
    step(); expect_st("r_exe", 4'd7, C_REXE);
    run = 1'b0;
    step(); expect_st("r_wb", 4'd8, C_RWB);
    step(); expect_st("r_idle", 4'd0, C_IDLE);
    step(); expect_st("r_idle_hold", 4'd0, C_IDLE);

    // Asynchronous reset in the middle of MEM_RD.
    run = 1'b1;
    Op  = 6'b100011;
    step(); expect_st("ar_fetch", 4'd1, C_FETCH);
    step(); expect_st("ar_decode", 4'd2, C_DECODE);
    step(); expect_st("ar_madr", 4'd3, C_MADR);
    step(); expect_st("ar_mrd", 4'd4, C_MRD);
    #1 rst_n = 1'b0;
    #1 expect_st("ar_async", 4'd0, C_IDLE);
    chk("ar_memread", {31'd0, MemRead}, 32'd0);
    @(negedge clk);
    expect_st("ar_held", 4'd0, C_IDLE);
    rst_n = 1'b1;
    step(); expect_st("ar_first_fetch", 4'd1, C_FETCH);

    // Unknown opcode goes to HALT and stays there whatever run does.
    Op = 6'b111111;
    step(); expect_st("halt_decode", 4'd2, C_DECODE);
    step(); expect_st("halt_enter", 4'd15, C_HALT);
    for (int i = 0; i < 10; i++) begin
      run = i[0];
      Op  = 6'b100011;
      step();
      expect_st($sformatf("halt_hold%0d", i), 4'd15, C_HALT);
    end

    // Reset releases HALT.
    #1 rst_n = 1'b0;
    #1 expect_st("halt_reset", 4'd0, C_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;
    step(); expect_st("halt_reset_idle", 4'd0, C_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
